fetch_redirect_unit: RTL

- Consumer of the branch/jump decision (`shouldJump` plus target) from the execute stage.
- Owns the architectural fetch PC and issues one-outstanding instruction-memory requests.
- Buffers one fetched instruction for decode.
- On redirect: discards wrong-path fetches, reloads the PC and pulses a pipeline flush.

---
 rtl/fetch_redirect_unit_pkg.sv | 25 ++
 rtl/fetch_pc_reg.sv | 34 +++
 rtl/fetch_redirect_unit.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/fetch_redirect_unit_pkg.sv
// fetch_redirect_unit_pkg
// Shared definitions for the fetch/redirect slice:
//   - default reset PC and the canonical NOP (addi x0,x0,0) encoding
//   - instruction/address width constants
//   - 2-bit FSM state encoding used by the fetch controller
//   - small helper that tests word alignment of a byte address
package fetch_redirect_unit_pkg;

    localparam int          ADDR_W           = 32;
    localparam int          INSTR_W          = 32;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2,
        S_HALT = 2'd3
    } fetchState_e;

    function automatic logic isWordAligned(input logic [1:0] lowBits);
        return (lowBits == 2'b00);
    endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// fetch_pc_reg
// Architectural fetch PC register.
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset, loads RESET_PC
//   loadEn     load loadValue (redirect); wins over incEn
//   loadValue  redirect destination
//   incEn      advance the PC by one instruction (4 bytes, wraps mod 2^XLEN)
//   pc         current PC value
module fetch_pc_reg #(
    parameter int               XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            loadEn,
    input  logic [XLEN-1:0] loadValue,
    input  logic            incEn,
    output logic [XLEN-1:0] pc
);

    // A redirect must beat a sequential advance: a response completing in the
    // same cycle as a redirect belongs to the wrong path.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (loadEn) begin
            pc <= loadValue;
        end else if (incEn) begin
            pc <= pc + XLEN'(4);
        end
    end

endmodule

// File: rtl/fetch_redirect_unit.sv
// fetch_redirect_unit
// Owns the fetch PC, issues single-outstanding instruction-memory requests,
// buffers one fetched instruction for decode and applies branch/jump redirects
// from execute (discarding wrong-path fetches and pulsing a flush).
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   redirect, redirectTarget      taken branch/jump and its destination
//   imemReqValid/Addr/Ready       fetch request handshake (address = fetchPc)
//   imemRspValid/Data             returned instruction word
//   ifValid/ifInstr/ifPc/ifReady  one-entry instruction buffer towards decode
//   flush                         registered one-cycle pulse after a redirect
//   misalign                      sticky flag: redirect target not word-aligned
//   fetchPc                       current fetch PC
module fetch_redirect_unit
    import fetch_redirect_unit_pkg::*;
#(
    parameter int               XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = DEFAULT_RESET_PC
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirectTarget,
    output logic            imemReqValid,
    output logic [XLEN-1:0] imemReqAddr,
    input  logic            imemReqReady,
    input  logic            imemRspValid,
    input  logic [XLEN-1:0] imemRspData,
    output logic            ifValid,
    output logic [XLEN-1:0] ifInstr,
    output logic [XLEN-1:0] ifPc,
    input  logic            ifReady,
    output logic            flush,
    output logic            misalign,
    output logic [XLEN-1:0] fetchPc
);

    fetchState_e state;
    fetchState_e nextState;
    logic        redirectTaken;
    logic        targetAligned;
    logic        issueReq;
    logic        bufferLoad;

    fetch_pc_reg #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) pcReg (
        .clk       (clk),
        .rst       (rst),
        .loadEn    (redirectTaken),
        .loadValue (redirectTarget),
        .incEn     (bufferLoad),
        .pc        (fetchPc)
    );

    assign imemReqAddr  = fetchPc;
    assign imemReqValid = issueReq;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_REQ;
        end else begin
            state <= nextState;
        end
    end

    // Next-state and request logic. A request only issues when the buffer
    // will be free by the time the word returns, so a response never finds
    // the buffer occupied. A redirect overrides the normal transitions; when
    // a redirect arrives while a response is still owed (WAIT or DROP with no
    // response this cycle) we go to DROP so that stale word is swallowed. If
    // the owed response lands in the redirect cycle itself nothing is
    // outstanding any more and fetching restarts straight away.
    always_comb begin
        nextState     = state;
        issueReq      = 1'b0;
        bufferLoad    = 1'b0;
        redirectTaken = redirect && (state != S_HALT);
        targetAligned = isWordAligned(redirectTarget[1:0]);

        case (state)
            S_REQ: begin
                issueReq = !redirect && (!ifValid || ifReady);
                if (issueReq && imemReqReady) begin
                    nextState = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imemRspValid) begin
                    bufferLoad = !redirectTaken;
                    nextState  = S_REQ;
                end
            end
            S_DROP: begin
                if (imemRspValid) begin
                    nextState = S_REQ;
                end
            end
            S_HALT: begin
                nextState = S_HALT;
            end
            default: begin
                nextState = S_REQ;
            end
        endcase

        if (redirectTaken) begin
            if (!targetAligned) begin
                nextState = S_HALT;
            end else if ((state == S_WAIT) || (state == S_DROP)) begin
                nextState = imemRspValid ? S_REQ : S_DROP;
            end else begin
                nextState = S_REQ;
            end
        end
    end

    // Output buffer, flush pulse and sticky misalign flag. A redirect empties
    // the buffer; a load beats a same-cycle consume so the new word stays.
    always_ff @(posedge clk) begin
        if (rst) begin
            ifValid  <= 1'b0;
            ifInstr  <= XLEN'(NOP_INSTR);
            ifPc     <= '0;
            flush    <= 1'b0;
            misalign <= 1'b0;
        end else begin
            flush <= redirectTaken;
            if (redirectTaken && !targetAligned) begin
                misalign <= 1'b1;
            end
            if (redirectTaken) begin
                ifValid <= 1'b0;
            end else if (bufferLoad) begin
                ifValid <= 1'b1;
                ifInstr <= imemRspData;
                ifPc    <= fetchPc;
            end else if (ifValid && ifReady) begin
                ifValid <= 1'b0;
            end
        end
    end

endmodule
